// File: rtl/sync_fifo_pkg.sv
// Shared constants and sizing helpers for the first-word-fall-through FIFO.
package sync_fifo_pkg;

    localparam int RST_BUSY_CYCLES = 2;

    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft_if.sv
// Producer/consumer handshake bundle for sync_fifo_fwft; clock and reset stay outside.
interface sync_fifo_fwft_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128
);
    localparam int CW = count_width(DEPTH);

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  data_valid;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  prog_full;
    logic                  prog_empty;
    logic [CW-1:0]         data_count;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  wr_rst_busy;
    logic                  rd_rst_busy;

    modport master (
        output wr_en, din, rd_en,
        input  dout, data_valid, empty, full, almost_full, almost_empty,
               prog_full, prog_empty, data_count, wr_ack, overflow, underflow,
               wr_rst_busy, rd_rst_busy
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, data_valid, empty, full, almost_full, almost_empty,
               prog_full, prog_empty, data_count, wr_ack, overflow, underflow,
               wr_rst_busy, rd_rst_busy
    );

endinterface

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port storage: synchronous write, registered read (old data on same-address collision).
module fifo_ram_sdp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 128,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FWFT FIFO: pointers, occupancy, reset-busy window and registered status flags.
module sync_fifo_fwft
    import sync_fifo_pkg::*;
#(
    parameter int                    DATA_WIDTH        = 32,
    parameter int                    DEPTH             = 128,
    parameter int                    PROG_FULL_THRESH  = 10,
    parameter int                    PROG_EMPTY_THRESH = 10,
    parameter logic [DATA_WIDTH-1:0] DOUT_RESET_VALUE  = '0,
    parameter bit                    FULL_RESET_VALUE  = 1'b0
) (
    input logic             clk_i,
    input logic             rst_i,
    sync_fifo_fwft_if.slave fifo_if
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
    localparam int BW = $clog2(RST_BUSY_CYCLES + 1);

    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [BW-1:0]         busy_cnt_q, busy_cnt_d;
    logic                  busy_q, busy_d;
    logic                  data_valid_q, data_valid_d;
    logic                  full_q, full_d;
    logic                  almost_full_q, almost_full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  prog_full_q, prog_full_d;
    logic                  prog_empty_q, prog_empty_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc, is_full;
    logic [DATA_WIDTH-1:0] ram_rd_data;

    // The RAM always reads the post-pop head address, so a popped word is replaced on the next edge.
    fifo_ram_sdp #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr_q),
        .wr_data (fifo_if.din),
        .rd_addr (rd_ptr_d),
        .rd_data (ram_rd_data)
    );

    always_comb begin
        is_full        = (count_q == CW'(DEPTH));
        wr_acc         = fifo_if.wr_en && !busy_q && !is_full;
        rd_acc         = fifo_if.rd_en && !busy_q && data_valid_q;
        wr_ptr_d       = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d       = rd_ptr_q + AW'(rd_acc);
        count_d        = count_q + CW'(wr_acc) - CW'(rd_acc);
        busy_cnt_d     = busy_cnt_q - BW'(busy_cnt_q != '0);
        busy_d         = (busy_cnt_q != '0);
        // A word landing in an otherwise empty RAM is not readable until the following edge.
        data_valid_d   = (count_d != '0) && !(wr_acc && (count_q == CW'(rd_acc)));
        full_d         = busy_d ? FULL_RESET_VALUE : (count_d == CW'(DEPTH));
        almost_full_d  = (count_d == CW'(DEPTH - 1));
        almost_empty_d = (count_d == CW'(1));
        prog_full_d    = (count_d >= CW'(PROG_FULL_THRESH));
        prog_empty_d   = (count_d <= CW'(PROG_EMPTY_THRESH));
        wr_ack_d       = wr_acc;
        overflow_d     = fifo_if.wr_en && !busy_q && is_full;
        underflow_d    = fifo_if.rd_en && !busy_q && !data_valid_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            busy_cnt_q     <= BW'(RST_BUSY_CYCLES);
            busy_q         <= 1'b1;
            data_valid_q   <= 1'b0;
            full_q         <= FULL_RESET_VALUE;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b0;
            prog_full_q    <= 1'b0;
            prog_empty_q   <= 1'b1;
            wr_ack_q       <= 1'b0;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            busy_cnt_q     <= busy_cnt_d;
            busy_q         <= busy_d;
            data_valid_q   <= data_valid_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            prog_full_q    <= prog_full_d;
            prog_empty_q   <= prog_empty_d;
            wr_ack_q       <= wr_ack_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    assign fifo_if.dout         = data_valid_q ? ram_rd_data : DOUT_RESET_VALUE;
    assign fifo_if.data_valid   = data_valid_q;
    assign fifo_if.empty        = !data_valid_q;
    assign fifo_if.full         = full_q;
    assign fifo_if.almost_full  = almost_full_q;
    assign fifo_if.almost_empty = almost_empty_q;
    assign fifo_if.prog_full    = prog_full_q;
    assign fifo_if.prog_empty   = prog_empty_q;
    assign fifo_if.data_count   = count_q;
    assign fifo_if.wr_ack       = wr_ack_q;
    assign fifo_if.overflow     = overflow_q;
    assign fifo_if.underflow    = underflow_q;
    assign fifo_if.wr_rst_busy  = busy_q;
    assign fifo_if.rd_rst_busy  = busy_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed checks of sync_fifo_fwft: reset window, FWFT latency, full/empty edges, wrap and mid-run reset.
module tb_sync_fifo_fwft;

    localparam int DW    = 32;
    localparam int DEPTH = 128;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    sync_fifo_fwft_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fifo_if ();

    sync_fifo_fwft #(
        .DATA_WIDTH        (DW),
        .DEPTH             (DEPTH),
        .PROG_FULL_THRESH  (10),
        .PROG_EMPTY_THRESH (10),
        .DOUT_RESET_VALUE  ('0),
        .FULL_RESET_VALUE  (1'b0)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .fifo_if (fifo_if.slave)
    );

    always #5 clk_i = ~clk_i;

    task automatic apply_stimulus(input logic rst, input logic wr, input logic [DW-1:0] data,
                                  input logic rd);
        rst_i         = rst;
        fifo_if.wr_en = wr;
        fifo_if.din   = data;
        fifo_if.rd_en = rd;
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        fifo_if.wr_en = 1'b0;
        fifo_if.din   = '0;
        fifo_if.rd_en = 1'b0;

        // Reset held for three edges.
        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, '0, 1'b0);
        check_output("rst_empty", fifo_if.empty, 1);
        check_output("rst_full", fifo_if.full, 0);
        check_output("rst_count", fifo_if.data_count, 0);
        check_output("rst_prog_empty", fifo_if.prog_empty, 1);
        check_output("rst_prog_full", fifo_if.prog_full, 0);
        check_output("rst_busy", fifo_if.wr_rst_busy, 1);
        check_output("rst_dout", fifo_if.dout, 0);

        // Writes during the busy window must be ignored.
        apply_stimulus(1'b0, 1'b1, 32'hAA, 1'b0);
        check_output("busy1_wr", fifo_if.wr_rst_busy, 1);
        check_output("busy1_rd", fifo_if.rd_rst_busy, 1);
        check_output("busy1_ack", fifo_if.wr_ack, 0);
        apply_stimulus(1'b0, 1'b1, 32'hAB, 1'b0);
        check_output("busy2_wr", fifo_if.wr_rst_busy, 1);
        check_output("busy2_ack", fifo_if.wr_ack, 0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        check_output("busy_end", fifo_if.wr_rst_busy, 0);
        check_output("busy_end_rd", fifo_if.rd_rst_busy, 0);
        check_output("busy_nostore", fifo_if.data_count, 0);
        check_output("busy_noack", fifo_if.wr_ack, 0);
        check_output("busy_empty", fifo_if.empty, 1);
        check_output("busy_full", fifo_if.full, 0);

        // Single word: one-cycle fall-through latency, then pop.
        apply_stimulus(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        check_output("one_ack", fifo_if.wr_ack, 1);
        check_output("one_count", fifo_if.data_count, 1);
        check_output("one_notyet", fifo_if.data_valid, 0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        check_output("one_valid", fifo_if.data_valid, 1);
        check_output("one_dout", fifo_if.dout, 32'hDEADBEEF);
        check_output("one_empty", fifo_if.empty, 0);
        check_output("one_almost_empty", fifo_if.almost_empty, 1);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        check_output("pop_empty", fifo_if.empty, 1);
        check_output("pop_count", fifo_if.data_count, 0);
        check_output("pop_dout", fifo_if.dout, 0);
        check_output("pop_underflow", fifo_if.underflow, 0);

        // Fill to capacity, watching every threshold flag.
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus(1'b0, 1'b1, DW'(i), 1'b0);
            check_output("fill_count", fifo_if.data_count, i + 1);
            check_output("fill_ack", fifo_if.wr_ack, 1);
            check_output("fill_afull", fifo_if.almost_full, (i + 1) == DEPTH - 1);
            check_output("fill_full", fifo_if.full, (i + 1) == DEPTH);
            check_output("fill_pfull", fifo_if.prog_full, (i + 1) >= 10);
            check_output("fill_pempty", fifo_if.prog_empty, (i + 1) <= 10);
        end
        apply_stimulus(1'b0, 1'b1, 32'd999, 1'b0);
        check_output("ovf_flag", fifo_if.overflow, 1);
        check_output("ovf_ack", fifo_if.wr_ack, 0);
        check_output("ovf_count", fifo_if.data_count, DEPTH);
        check_output("ovf_full", fifo_if.full, 1);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        check_output("ovf_clear", fifo_if.overflow, 0);

        // Drain: words must come out in write order.
        for (int i = 0; i < DEPTH; i++) begin
            check_output("drain_valid", fifo_if.data_valid, 1);
            check_output("drain_dout", fifo_if.dout, i);
            apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        end
        check_output("drain_empty", fifo_if.empty, 1);
        check_output("drain_count", fifo_if.data_count, 0);
        check_output("drain_full", fifo_if.full, 0);

        // Pop request on an empty FIFO.
        apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        check_output("udf_flag", fifo_if.underflow, 1);
        check_output("udf_dout", fifo_if.dout, 0);
        check_output("udf_count", fifo_if.data_count, 0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        check_output("udf_clear", fifo_if.underflow, 0);

        // Steady simultaneous traffic at occupancy 5, crossing the pointer wrap.
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, DW'(1000 + i), 1'b0);
        check_output("ss_prefill", fifo_if.data_count, 5);
        for (int k = 0; k < 300; k++) begin
            check_output("ss_dout", fifo_if.dout, 1000 + k);
            apply_stimulus(1'b0, 1'b1, DW'(1005 + k), 1'b1);
            check_output("ss_count", fifo_if.data_count, 5);
            check_output("ss_ack", fifo_if.wr_ack, 1);
            check_output("ss_valid", fifo_if.data_valid, 1);
        end
        check_output("ss_tail", fifo_if.dout, 1300);

        // Top up to 50 words, then reset mid-operation.
        for (int i = 0; i < 45; i++) apply_stimulus(1'b0, 1'b1, DW'(2000 + i), 1'b0);
        check_output("mid_count", fifo_if.data_count, 50);
        check_output("mid_pfull", fifo_if.prog_full, 1);
        apply_stimulus(1'b1, 1'b0, '0, 1'b0);
        check_output("mid_rst_empty", fifo_if.empty, 1);
        check_output("mid_rst_count", fifo_if.data_count, 0);
        check_output("mid_rst_busy", fifo_if.wr_rst_busy, 1);
        check_output("mid_rst_dout", fifo_if.dout, 0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        check_output("mid_busy1", fifo_if.rd_rst_busy, 1);
        check_output("mid_busy1_udf", fifo_if.underflow, 0);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        check_output("mid_busy2", fifo_if.rd_rst_busy, 1);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        check_output("mid_busy_end", fifo_if.rd_rst_busy, 0);
        apply_stimulus(1'b0, 1'b1, 32'h1, 1'b0);
        check_output("post_ack", fifo_if.wr_ack, 1);
        apply_stimulus(1'b0, 1'b0, '0, 1'b0);
        check_output("post_valid", fifo_if.data_valid, 1);
        check_output("post_dout", fifo_if.dout, 32'h1);
        check_output("post_count", fifo_if.data_count, 1);
        apply_stimulus(1'b0, 1'b0, '0, 1'b1);
        check_output("post_empty", fifo_if.empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
